// File: rtl/game_pkg.sv
// game_pkg: colour/state types and sequence length encoding shared by capture and playback.
package game_pkg;
  typedef logic [1:0] colour_t;
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;
  localparam int SEQ_MAX_LEN = 16;
  // A 4-bit length code of 0 stands for a full 16-colour sequence.
  function automatic logic [4:0] seq_len(input logic [3:0] code);
    return (code == 4'd0) ? 5'(SEQ_MAX_LEN) : {1'b0, code};
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter; done while the count sits at zero.
module phase_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = (cnt_q == '0);
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays a latched colour sequence as ON/OFF phases, first colour at the top bit pair.
module sequence_player
  import game_pkg::*;
#(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500,
  parameter int CNT_W = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] sequence_val,
  input  logic [3:0]  sequence_len,
  output logic [1:0]  colour_out,
  output logic        led_on,
  output logic        colour_valid,
  output logic        busy,
  output logic        complete_play
);
  state_t      state_q, state_d;
  logic [31:0] seq_q, seq_d;
  logic [3:0]  idx_q, idx_d;
  colour_t     colour_q, colour_d;
  logic        led_q, led_d, valid_q, valid_d, busy_q, busy_d, cmpl_q, cmpl_d;
  logic        t_load, t_done;
  logic [CNT_W-1:0] t_val;
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: if (en) begin
        state_d = S_ON;
        seq_d   = sequence_val;
        idx_d   = 4'(seq_len(sequence_len) - 5'd1);
      end
      S_ON:   state_d = !en ? S_IDLE : t_done ? S_OFF : S_ON;
      S_OFF:  if (!en) state_d = S_IDLE;
              else if (t_done) begin
                state_d = (idx_q == 4'd0) ? S_DONE : S_ON;
                idx_d   = (idx_q == 4'd0) ? idx_q : idx_q - 4'd1;
              end
      S_DONE: state_d = en ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are derived from the next state.
    colour_d = (state_d == S_ON) ? seq_d[{idx_d, 1'b0} +: 2] : 2'd0;
    led_d    = (state_d == S_ON);
    valid_d  = (state_d == S_ON) && (state_q != S_ON);
    busy_d   = (state_d == S_ON) || (state_d == S_OFF);
    cmpl_d   = (state_d == S_DONE);
    t_load   = (state_d != state_q);
    t_val    = (state_d == S_ON)  ? CNT_W'(ON_CYCLES - 1)
             : (state_d == S_OFF) ? CNT_W'(OFF_CYCLES - 1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      seq_q    <= '0;
      idx_q    <= '0;
      colour_q <= '0;
      led_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cmpl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      colour_q <= colour_d;
      led_q    <= led_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      cmpl_q   <= cmpl_d;
    end
  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );
  assign colour_out    = colour_q;
  assign led_on        = led_q;
  assign colour_valid  = valid_q;
  assign busy          = busy_q;
  assign complete_play = cmpl_q;
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed playback scenarios; a colour_valid monitor pops expected colours from a queue.
module tb_sequence_player;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] sequence_val = '0;
  logic [3:0]  sequence_len = '0;
  logic [1:0]  colour_out;
  logic        led_on, colour_valid, busy, complete_play;
  int          pass_cnt = 0;
  int          total = 0;
  logic [1:0]  exp_q[$];

  sequence_player #(.ON_CYCLES(3), .OFF_CYCLES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .sequence_val  (sequence_val),
    .sequence_len  (sequence_len),
    .colour_out    (colour_out),
    .led_on        (led_on),
    .colour_valid  (colour_valid),
    .busy          (busy),
    .complete_play (complete_play)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    check({name, "_outs"}, {colour_out, led_on, colour_valid, busy, complete_play}, 6'd0);
  endtask

  task automatic start(input logic [31:0] v, input logic [3:0] l);
    sequence_val = v;
    sequence_len = l;
    en = 1'b1;
  endtask

  always @(negedge clk)
    if (colour_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_colour: got %0d expected none", colour_out);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("colour_valid_colour", {led_on, colour_out}, {1'b1, e});
      end
    end

  initial begin
    logic [1:0] trace [15] = '{2,2,2,0,0,1,1,1,0,0,3,3,3,0,0};
    #2 check_idle("reset");
    step(1);
    check_idle("reset_clocked");
    rst_n = 1'b1;
    step(2);
    check_idle("idle_no_en");

    // Basic L=3 playback, cycle-exact trace
    start(32'h27, 4'd3);
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(3);
    for (int k = 1; k <= 15; k++) begin
      step(1);
      check($sformatf("trace_colour_%0d", k), colour_out, trace[k-1]);
      check($sformatf("trace_valid_%0d", k), colour_valid, (k == 1 || k == 6 || k == 11));
      check($sformatf("trace_busy_%0d", k), {busy, complete_play}, 2'b10);
    end
    step(1);
    check("done_offset16", {complete_play, busy, led_on}, 3'b100);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("done_hold", {complete_play, busy, colour_valid}, 3'b100);
    end
    en = 1'b0;
    step(1);
    check_idle("done_release");

    // L=0 encodes 16 colours
    start(32'hE4E4E4E4, 4'd0);
    for (int k = 0; k < 16; k++) exp_q.push_back(2'(3 - (k % 4)));
    step(80);
    check("len16_before_done", complete_play, 1'b0);
    step(1);
    check("len16_done", {complete_play, busy}, 2'b10);
    en = 1'b0;
    step(1);
    check_idle("len16_release");

    // Input changes after start are ignored
    start(32'h27, 4'd3);
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(3);
    step(7);
    sequence_val = 32'h0;
    sequence_len = 4'd1;
    step(9);
    check("latch_done", complete_play, 1'b1);
    en = 1'b0;
    step(1);
    check_idle("latch_release");

    // Abort in first OFF, then restart from the first colour
    start(32'h39, 4'd3);
    exp_q.push_back(3);
    step(4);
    check("abort_off_phase", {busy, led_on, colour_out}, 4'b1000);
    en = 1'b0;
    step(1);
    check_idle("abort_idle");
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("abort_no_complete", {complete_play, busy}, 2'b00);
    end
    start(32'h39, 4'd3);
    exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1);
    step(1);
    check("restart_first", {colour_valid, led_on, colour_out}, 4'b1111);
    step(15);
    check("restart_done", complete_play, 1'b1);
    en = 1'b0;
    step(1);
    check_idle("restart_release");

    // Async reset mid-ON
    start(32'h27, 4'd3);
    exp_q.push_back(2);
    step(2);
    check("pre_reset_on", {led_on, busy, colour_out}, 4'b1110);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1 check_idle("async_reset");
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_idle("post_reset_idle");
    end
    start(32'h27, 4'd3);
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(3);
    step(16);
    check("post_reset_done", complete_play, 1'b1);
    en = 1'b0;
    step(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
